// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo interleave front end.
//   LLR_W      : soft LLR width per lane
//   LANES      : lanes per interleave group
//   llr_grp_t  : one 4-lane LLR group, lane 0 in element [0]
//   pack_state_e : packer FSM states
package turbo_pkg;

    localparam int LLR_W = 16;
    localparam int LANES = 4;

    typedef logic [LANES-1:0][LLR_W-1:0] llr_grp_t;

    typedef enum logic {
        HUNT = 1'b0,
        FILL = 1'b1
    } pack_state_e;

endpackage

// File: rtl/llr_group_oreg.sv
// Output register for one LLR group with valid/ready hold.
//   clk, rst   : clock, synchronous active-low reset
//   load_i     : load grp_i/sof_i/eof_i this edge (only asserted when free_o)
//   grp_i      : group to load
//   sof_i/eof_i: frame boundary flags for the loaded group
//   ready_i    : downstream accepts the presented group
//   grp_o, valid_o, sof_o, eof_o : registered group and flags
//   free_o     : register can take a new group at the next edge
module llr_group_oreg
    import turbo_pkg::*;
#(
    parameter int W = LLR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_i,
    input  logic [LANES-1:0][W-1:0]    grp_i,
    input  logic                       sof_i,
    input  logic                       eof_i,
    input  logic                       ready_i,
    output logic [LANES-1:0][W-1:0]    grp_o,
    output logic                       valid_o,
    output logic                       sof_o,
    output logic                       eof_o,
    output logic                       free_o
);

    logic [LANES-1:0][W-1:0] grp_q;
    logic                    valid_q, valid_d;
    logic                    sof_q, eof_q;

    assign free_o = !valid_q || ready_i;

    // A load replaces a group being handed off in the same cycle.
    always_comb begin
        valid_d = valid_q;
        if (load_i)       valid_d = 1'b1;
        else if (ready_i) valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            grp_q   <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (load_i) begin
                grp_q <= grp_i;
                sof_q <= sof_i;
                eof_q <= eof_i;
            end
        end
    end

    assign grp_o   = grp_q;
    assign valid_o = valid_q;
    assign sof_o   = sof_q;
    assign eof_o   = eof_q;

endmodule

// File: rtl/llr_group_pack.sv
// Packs a 1-symbol/cycle soft LLR stream into 4-lane groups for the
// turbo interleave stage, zero-padding the last partial group of a frame.
//   clk, rst          : clock, synchronous active-low reset
//   in_data/in_valid/in_sof/in_ready : input symbol stream
//   out_x1..out_x4    : group lanes 0..3 in arrival order
//   out_valid/out_ready : group handshake
//   out_sof/out_eof   : group holds the first / last symbol of the frame
//   frame_err         : one-cycle pulse when in_sof arrives mid-frame
module llr_group_pack
    import turbo_pkg::*;
#(
    parameter int W         = LLR_W,
    parameter int FRAME_LEN = 40,
    parameter int CNT_W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_sof,
    output logic         in_ready,
    output logic [W-1:0] out_x1,
    output logic [W-1:0] out_x2,
    output logic [W-1:0] out_x3,
    output logic [W-1:0] out_x4,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sof,
    output logic         out_eof,
    output logic         frame_err
);

    pack_state_e             state_q, state_d;
    logic [1:0]              lane_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [LANES-1:0][W-1:0] col_q;
    logic                    sof_flag_q, eof_flag_q, pend_q, frame_err_q;

    logic                    accept, restart, store, premature, last, close;
    logic                    out_free, load, load_sof, load_eof;
    logic [2:0]              lane_new;
    logic [CNT_W-1:0]        cnt_new;
    logic                    sof_new;
    logic [LANES-1:0][W-1:0] col_new, load_grp, grp_o;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= HUNT;
        else      state_q <= state_d;
    end

    // Next state: any stored symbol that completes the frame returns to HUNT
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:    if (store) state_d = last ? HUNT : FILL;
            FILL:    if (last)  state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // Outputs / datapath control
    always_comb begin
        in_ready  = !pend_q;
        accept    = in_valid && in_ready;
        restart   = accept && in_sof;
        store     = accept && (state_q == FILL || in_sof);
        premature = restart && state_q == FILL;

        // A restart discards any partial group collected so far.
        col_new = restart ? '0 : col_q;
        if (restart) col_new[0]      = in_data;
        else         col_new[lane_q] = in_data;
        lane_new = restart ? 3'd1 : {1'b0, lane_q} + 3'd1;
        cnt_new  = restart ? CNT_W'(1) : cnt_q + CNT_W'(1);
        sof_new  = restart || sof_flag_q;

        last  = store && cnt_new == CNT_W'(FRAME_LEN);
        close = store && (lane_new == 3'(LANES) || last);

        // close and pend_q are exclusive: no accepts while pending
        load     = (close || pend_q) && out_free;
        load_grp = pend_q ? col_q      : col_new;
        load_sof = pend_q ? sof_flag_q : sof_new;
        load_eof = pend_q ? eof_flag_q : last;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lane_q      <= '0;
            cnt_q       <= '0;
            col_q       <= '0;
            sof_flag_q  <= 1'b0;
            eof_flag_q  <= 1'b0;
            pend_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= premature;
            if (store) begin
                cnt_q <= last ? '0 : cnt_new;
                if (close) begin
                    lane_q <= '0;
                    if (out_free) begin
                        col_q      <= '0;
                        sof_flag_q <= 1'b0;
                    end else begin
                        // Park the closed group; flags travel with it
                        col_q      <= col_new;
                        sof_flag_q <= sof_new;
                        eof_flag_q <= last;
                        pend_q     <= 1'b1;
                    end
                end else begin
                    lane_q     <= lane_new[1:0];
                    col_q      <= col_new;
                    sof_flag_q <= sof_new;
                end
            end else if (pend_q && out_free) begin
                pend_q     <= 1'b0;
                col_q      <= '0;
                sof_flag_q <= 1'b0;
                eof_flag_q <= 1'b0;
            end
        end
    end

    llr_group_oreg #(.W(W)) u_oreg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .grp_i   (load_grp),
        .sof_i   (load_sof),
        .eof_i   (load_eof),
        .ready_i (out_ready),
        .grp_o   (grp_o),
        .valid_o (out_valid),
        .sof_o   (out_sof),
        .eof_o   (out_eof),
        .free_o  (out_free)
    );

    assign out_x1    = grp_o[0];
    assign out_x2    = grp_o[1];
    assign out_x3    = grp_o[2];
    assign out_x4    = grp_o[3];
    assign frame_err = frame_err_q;

endmodule

// File: doc/llr_group_pack.md
Name: llr_group_pack

Overview:
- Upstream feeder of the 4-lane turbo interleave stage.
- Accepts one 16-bit soft LLR per cycle on a valid/ready stream and packs consecutive symbols into 4-lane groups (lanes x1..x4).
- Tracks frame boundaries and zero-pads the final partial group of a frame.
- Presents each group on a registered output with valid/ready backpressure, so the lanes can feed the interleave register directly.

Parameters:
- W, 16, LLR width per lane.
- FRAME_LEN, 40, symbols per frame (>=1; need not be a multiple of 4).
- CNT_W, 16, width of the symbol counter (must satisfy 2^CNT_W > FRAME_LEN).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- in_data  in  W  soft LLR symbol.
- in_valid  in  1  in_data valid.
- in_sof  in  1  marks the first symbol of a frame; qualified by in_valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_x1 / out_x2 / out_x3 / out_x4  out  W each  lanes 0..3 of the group, in arrival order.
- out_valid  out  1  group valid.
- out_ready  in  1  downstream accepts the group.
- out_sof  out  1  this group holds the frame's first symbol.
- out_eof  out  1  this group holds the frame's last symbol.
- frame_err  out  1  one-cycle pulse on a premature in_sof.

Behaviour:
- Reset (rst=0 at a clk edge): all out_x*=0, out_valid=0, out_sof=0, out_eof=0, frame_err=0; lane index=0, symbol count=0, pend=0, state=HUNT. Reset mid-frame discards all collected data.
- Accept = in_valid && in_ready.
- in_ready = !pend; it is combinational from registered state only.
- States:
  - HUNT: accepted symbols without in_sof are consumed and dropped. An accept with in_sof stores the symbol as lane 0, sets count=1 and a sof_flag, then goes to FILL.
  - FILL: each accept stores into the current lane, increments the lane index and count.
- Group close happens on the accept that fills lane 3, or on the accept where count reaches FRAME_LEN (last symbol).
  - Unfilled lanes are 0.
  - eof is attached when the close was caused by the last symbol.
  - After a last-symbol close: count=0, state=HUNT.
- Transfer on close:
  - Output is free when out_valid==0 || out_ready. If free at the closing edge, the group loads the output regs at that same edge, so out_valid rises the cycle after the last accept (latency 1).
  - Otherwise the group is held in the collection regs with pend=1. While pend=1, in_ready=0. The group transfers at the first edge where the output is free; pend clears at that edge.
- Throughput: sustained 1 symbol/cycle when out_ready is held high; no bubbles.
- Output hold: while out_valid && !out_ready, out_x*, out_sof and out_eof are stable. out_valid clears on the handshake if no new group loads.
- out_sof=1 only on the first group after the in_sof accept.
- Premature sof: in_sof accepted while in FILL (count != 0).
  - frame_err pulses for 1 cycle.
  - The partial group is discarded; nothing is emitted for it.
  - The accepted symbol restarts the frame as lane 0, count=1.
  - A group already in the output reg is unaffected.
- FRAME_LEN=1: every sof symbol yields one group (sym,0,0,0) with sof=eof=1.
- Simultaneous output handshake and group close: the new group replaces the old one at the same edge, and out_valid stays 1.

Decomposition:
- Shared package turbo_pkg: LLR width W, lane count 4, typedef of the 4-lane LLR group.
- One sub-module: llr_group_oreg, the output register with valid/ready hold logic and sof/eof flags.
- The packer FSM, counters and pend logic stay in the top.

Test Plan:
All scenarios use FRAME_LEN=10, with symbols 1..N in hex.
- Full-rate frame: in_sof on symbol 1, symbols 1..10 back-to-back, out_ready=1 -> groups (1,2,3,4) sof, (5,6,7,8), (9,10,0,0) eof. Each group is valid the cycle after its closing accept; in_ready stays 1.
- Backpressure: out_ready=0 from the first group -> the second group goes to pend after symbol 8 and in_ready drops. When out_ready rises, the groups drain in order with no loss or duplication, and the output is stable while stalled.
- Hunt: 3 symbols without sof, then a frame -> the 3 symbols are dropped, the output is identical to scenario 1, and frame_err stays 0.
- Premature sof: sof, symbols 1..6, then sof at symbol 7 followed by 9 more -> (1,2,3,4) is emitted, (5,6) is discarded, frame_err pulses once, and the new frame emits 3 groups starting with sof.
- Reset mid-frame: rst=0 after symbol 3 -> all outputs go to 0 the next cycle, the block returns to HUNT, and a following frame packs correctly.
- Back-to-back frames with in_valid gaps and random out_ready -> each frame emits exactly 3 groups, and the sof/eof flags are correct on every group.
